// File: rtl/fmc_seq_pkg.sv
// Shared types and default sizing for the FMC test-chip sequencer.
package fmc_seq_pkg;

   localparam int unsigned DEF_DW       = 128;
   localparam int unsigned DEF_CNT_W    = 8;
   localparam int unsigned DEF_RST_CYC  = 16;
   localparam int unsigned DEF_SCK_DIV  = 2;
   localparam int unsigned DEF_TURN_CYC = 4;

   typedef enum logic [2:0] {
      StIdle,
      StRst,
      StClkSw,
      StWrWait,
      StWrXfer,
      StTurn,
      StRdXfer,
      StDone
   } seq_state_e;

endpackage

// File: rtl/fmc_sck_gen.sv
// Transfer strobe generator: SCK_DIV cycles low, SCK_DIV cycles high per word while run_i is
// high. Strobe is registered; half_end_o/word_end_o flag the last low/high cycle of a word.
module fmc_sck_gen
   import fmc_seq_pkg::*;
#(
   parameter int unsigned SCK_DIV = DEF_SCK_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   output logic sck_o,
   output logic half_end_o,
   output logic word_end_o
);

   localparam int unsigned LAST = 2 * SCK_DIV - 1;
   localparam int unsigned CW   = $clog2(2 * SCK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;

   assign half_end_o = run_i && (cnt_q == CW'(SCK_DIV - 1));
   assign word_end_o = run_i && (cnt_q == CW'(LAST));
   assign sck_o      = sck_q;

   // Position within the word and the strobe level for the next cycle.
   always_comb begin
      cnt_d = '0;
      sck_d = 1'b0;
      if (run_i) begin
         cnt_d = word_end_o ? '0 : cnt_q + 1'b1;
         sck_d = half_end_o ? 1'b1 : (word_end_o ? 1'b0 : sck_q);
      end
   end

   // Counter and strobe registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/fmc_chip_seq.sv
// FMC test-chip sequencer: chip reset, clock switch, config write burst, bus turnaround and
// result read burst over the shared pad bus. Every output is a flop.
module fmc_chip_seq
   import fmc_seq_pkg::*;
#(
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned RST_CYC  = DEF_RST_CYC,
   parameter int unsigned SCK_DIV  = DEF_SCK_DIV,
   parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_start,
   input  logic [CNT_W-1:0] I_wr_num,
   input  logic [CNT_W-1:0] I_rd_num,
   input  logic [DW-1:0]    I_wr_data,
   input  logic             I_wr_val,
   output logic             O_wr_rdy,
   output logic [DW-1:0]    O_rd_data,
   output logic             O_rd_val,
   output logic             O_busy,
   output logic             O_done,
   output logic             O_reset_n,
   output logic             O_SW_clk,
   output logic             O_spi_cs_n,
   output logic             O_spi_sck,
   output logic             O_OE_req,
   output logic             O_in_1,
   output logic             O_in_2,
   output logic [DW-1:0]    O_pad_dout,
   output logic             O_pad_oe,
   input  logic [DW-1:0]    I_pad_din
);

   localparam int unsigned CYC_MAX = (RST_CYC > TURN_CYC) ? RST_CYC : TURN_CYC;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX) + 1;

   seq_state_e       state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] wr_left_q, wr_left_d, rd_left_q, rd_left_d;
   logic             sck_run, half_end, word_end;

   logic             chip_up_q, chip_up_d;
   logic             cs_n_q, cs_n_d, in_1_q, in_1_d, in_2_q, in_2_d;
   logic             wr_rdy_q, wr_rdy_d, oe_req_q, oe_req_d, pad_oe_q, pad_oe_d;
   logic             rd_val_q, rd_val_d, busy_q, busy_d, done_q, done_d;
   logic [DW-1:0]    pad_dout_q, pad_dout_d, rd_data_q, rd_data_d;

   assign sck_run = (state_q == StWrXfer) || (state_q == StRdXfer);

   fmc_sck_gen #(
      .SCK_DIV (SCK_DIV)
   ) u_sck_gen (
      .clk_i      (I_clk),
      .rst_i      (I_rst),
      .run_i      (sck_run),
      .sck_o      (O_spi_sck),
      .half_end_o (half_end),
      .word_end_o (word_end)
   );

   // State, phase timer and word counters.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q   <= StIdle;
         cyc_q     <= '0;
         wr_left_q <= '0;
         rd_left_q <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         wr_left_q <= wr_left_d;
         rd_left_q <= rd_left_d;
      end
   end

   // Next state. Word counts drop at mid-word so word_end only needs a zero test.
   always_comb begin
      state_d   = state_q;
      wr_left_d = wr_left_q;
      rd_left_d = rd_left_q;
      unique case (state_q)
         StIdle: begin
            if (I_start) begin
               state_d   = StRst;
               wr_left_d = I_wr_num;
               rd_left_d = I_rd_num;
            end
         end
         StRst: if (cyc_q == CYC_W'(RST_CYC - 1)) state_d = StClkSw;
         StClkSw: begin
            if (cyc_q == CYC_W'(RST_CYC - 1)) begin
               if (wr_left_q != '0)      state_d = StWrWait;
               else if (rd_left_q != '0) state_d = StTurn;
               else                      state_d = StDone;
            end
         end
         StWrWait: if (I_wr_val && wr_rdy_q) state_d = StWrXfer;
         StWrXfer: begin
            if (half_end) wr_left_d = wr_left_q - 1'b1;
            if (word_end) begin
               if (wr_left_q != '0)      state_d = StWrWait;
               else if (rd_left_q != '0) state_d = StTurn;
               else                      state_d = StDone;
            end
         end
         StTurn: if (cyc_q == CYC_W'(TURN_CYC - 1)) state_d = StRdXfer;
         StRdXfer: begin
            if (half_end) rd_left_d = rd_left_q - 1'b1;
            if (word_end && (rd_left_q == '0)) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Timer restarts on every state change; its value only matters in timed states.
      cyc_d = (state_d != state_q) ? '0 : cyc_q + 1'b1;
   end

   // Output next-values, decoded from the state being entered so outputs align with it.
   always_comb begin
      chip_up_d  = chip_up_q;
      cs_n_d     = 1'b1;
      in_1_d     = 1'b0;
      in_2_d     = 1'b0;
      wr_rdy_d   = 1'b0;
      oe_req_d   = 1'b0;
      pad_oe_d   = 1'b0;
      pad_dout_d = pad_dout_q;
      rd_val_d   = 1'b0;
      rd_data_d  = rd_data_q;
      busy_d     = (state_d != StIdle);
      done_d     = (state_d == StDone);
      unique case (state_d)
         StIdle: begin
         end
         StRst:   chip_up_d = 1'b0;
         StClkSw: chip_up_d = 1'b1;
         StWrWait: begin
            chip_up_d = 1'b1;
            cs_n_d    = 1'b0;
            in_1_d    = 1'b1;
            wr_rdy_d  = 1'b1;
            pad_oe_d  = pad_oe_q;
         end
         StWrXfer: begin
            chip_up_d = 1'b1;
            cs_n_d    = 1'b0;
            in_1_d    = 1'b1;
            pad_oe_d  = 1'b1;
         end
         StTurn: begin
            chip_up_d = 1'b1;
            oe_req_d  = 1'b1;
         end
         StRdXfer: begin
            chip_up_d = 1'b1;
            oe_req_d  = 1'b1;
            in_2_d    = 1'b1;
         end
         StDone:  chip_up_d = 1'b1;
         default: chip_up_d = 1'b0;
      endcase
      if (I_wr_val && wr_rdy_q) pad_dout_d = I_wr_data;
      if ((state_q == StRdXfer) && word_end) begin
         rd_val_d  = 1'b1;
         rd_data_d = I_pad_din;
      end
   end

   // Output registers.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         chip_up_q  <= 1'b0;
         cs_n_q     <= 1'b1;
         in_1_q     <= 1'b0;
         in_2_q     <= 1'b0;
         wr_rdy_q   <= 1'b0;
         oe_req_q   <= 1'b0;
         pad_oe_q   <= 1'b0;
         pad_dout_q <= '0;
         rd_val_q   <= 1'b0;
         rd_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         chip_up_q  <= chip_up_d;
         cs_n_q     <= cs_n_d;
         in_1_q     <= in_1_d;
         in_2_q     <= in_2_d;
         wr_rdy_q   <= wr_rdy_d;
         oe_req_q   <= oe_req_d;
         pad_oe_q   <= pad_oe_d;
         pad_dout_q <= pad_dout_d;
         rd_val_q   <= rd_val_d;
         rd_data_q  <= rd_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Reset release and clock switch always move together.
   assign O_reset_n  = chip_up_q;
   assign O_SW_clk   = chip_up_q;
   assign O_spi_cs_n = cs_n_q;
   assign O_in_1     = in_1_q;
   assign O_in_2     = in_2_q;
   assign O_wr_rdy   = wr_rdy_q;
   assign O_OE_req   = oe_req_q;
   assign O_pad_oe   = pad_oe_q;
   assign O_pad_dout = pad_dout_q;
   assign O_rd_val   = rd_val_q;
   assign O_rd_data  = rd_data_q;
   assign O_busy     = busy_q;
   assign O_done     = done_q;

endmodule

// File: tb/tb_fmc_chip_seq.sv
// Bench for fmc_chip_seq: a phase-level timeline of expected outputs (plus the inputs to drive
// each cycle) is built per scenario and compared against the DUT every cycle.
module tb_fmc_chip_seq;

   localparam int unsigned DW       = 128;
   localparam int unsigned RST_CYC  = 16;
   localparam int unsigned SCK_DIV  = 2;
   localparam int unsigned TURN_CYC = 4;

   logic          I_clk = 1'b0;
   logic          I_rst, I_start, I_wr_val;
   logic [7:0]    I_wr_num, I_rd_num;
   logic [DW-1:0] I_wr_data, I_pad_din;
   logic          O_wr_rdy, O_rd_val, O_busy, O_done, O_reset_n, O_SW_clk, O_spi_cs_n;
   logic          O_spi_sck, O_OE_req, O_in_1, O_in_2, O_pad_oe;
   logic [DW-1:0] O_rd_data, O_pad_dout;

   fmc_chip_seq #(
      .DW       (DW),
      .CNT_W    (8),
      .RST_CYC  (RST_CYC),
      .SCK_DIV  (SCK_DIV),
      .TURN_CYC (TURN_CYC)
   ) dut (
      .I_clk      (I_clk),
      .I_rst      (I_rst),
      .I_start    (I_start),
      .I_wr_num   (I_wr_num),
      .I_rd_num   (I_rd_num),
      .I_wr_data  (I_wr_data),
      .I_wr_val   (I_wr_val),
      .O_wr_rdy   (O_wr_rdy),
      .O_rd_data  (O_rd_data),
      .O_rd_val   (O_rd_val),
      .O_busy     (O_busy),
      .O_done     (O_done),
      .O_reset_n  (O_reset_n),
      .O_SW_clk   (O_SW_clk),
      .O_spi_cs_n (O_spi_cs_n),
      .O_spi_sck  (O_spi_sck),
      .O_OE_req   (O_OE_req),
      .O_in_1     (O_in_1),
      .O_in_2     (O_in_2),
      .O_pad_dout (O_pad_dout),
      .O_pad_oe   (O_pad_oe),
      .I_pad_din  (I_pad_din)
   );

   always #5 I_clk = ~I_clk;

   // One cycle of the timeline: inputs to drive, then outputs required in that cycle.
   typedef struct {
      logic          rst, start, wr_val;
      logic [7:0]    wr_num, rd_num;
      logic [DW-1:0] wr_data, pad_din;
      logic          reset_n, sw_clk, cs_n, sck, oe_req, in_1, in_2, pad_oe, wr_rdy;
      logic          rd_val, busy, done, chk_dout, chk_rdata, mark;
      logic [DW-1:0] dout, rdata;
   } cyc_t;

   cyc_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cur;
   bit   chip_up;
   int   rd_first_idx;
   int   n_rstlow, n_swhi, first_rdy, done_off, n_rdval, rd_gap, last_rdval, n_done, n_oe;
   int   n_sck_rise;
   logic sck_prev;

   function automatic logic [DW-1:0] wword(int w);
      logic [31:0] x;
      x = 32'h5A00_0000 + 32'(w);
      return {x, ~x, 32'hCAFE_F00D, x ^ 32'h0F0F_0F0F};
   endfunction

   function automatic logic [DW-1:0] rword(int r);
      logic [31:0] x;
      x = 32'h3C00_0100 + 32'(r);
      return {32'h1234_5678, x, x ^ 32'hFFFF_0000, ~x};
   endfunction

   function automatic cyc_t blank();
      cyc_t c;
      c.rst = 1'b0; c.start = 1'b0; c.wr_val = 1'b0; c.wr_num = '0; c.rd_num = '0;
      c.wr_data = '0; c.pad_din = {4{32'hDEAD_BEEF}};
      c.reset_n = chip_up; c.sw_clk = chip_up; c.cs_n = 1'b1; c.sck = 1'b0;
      c.oe_req = 1'b0; c.in_1 = 1'b0; c.in_2 = 1'b0; c.pad_oe = 1'b0; c.wr_rdy = 1'b0;
      c.rd_val = 1'b0; c.busy = 1'b0; c.done = 1'b0; c.chk_dout = 1'b0; c.chk_rdata = 1'b0;
      c.mark = 1'b0; c.dout = '0; c.rdata = '0;
      return c;
   endfunction

   // Appends one full sequence: start, reset hold, clock switch, writes, turn, reads, done.
   task automatic build_seq(input int wn, input int rn, input int stall0, input bit bogus);
      cyc_t c;
      c = blank(); c.start = 1'b1; c.wr_num = 8'(wn); c.rd_num = 8'(rn); c.mark = 1'b1;
      q.push_back(c);
      for (int k = 0; k < int'(RST_CYC); k++) begin
         c = blank(); c.busy = 1'b1; c.reset_n = 1'b0; c.sw_clk = 1'b0;
         if (bogus && k == 5) begin
            c.start = 1'b1; c.wr_num = 8'hFF; c.rd_num = 8'hFF;
         end
         q.push_back(c);
      end
      chip_up = 1'b1;
      for (int k = 0; k < int'(RST_CYC); k++) begin
         c = blank(); c.busy = 1'b1; q.push_back(c);
      end
      for (int w = 0; w < wn; w++) begin
         for (int s = 0; s <= ((w == 0) ? stall0 : 0); s++) begin
            c = blank(); c.busy = 1'b1; c.cs_n = 1'b0; c.in_1 = 1'b1; c.wr_rdy = 1'b1;
            c.pad_oe = (w > 0); c.chk_dout = (w > 0); c.dout = wword(w - 1);
            c.wr_val = (s == ((w == 0) ? stall0 : 0));
            c.wr_data = c.wr_val ? wword(w) : ~wword(w);
            if (bogus && s == 3) begin
               c.start = 1'b1; c.wr_num = 8'h07; c.rd_num = 8'h07;
            end
            q.push_back(c);
         end
         for (int k = 0; k < int'(2 * SCK_DIV); k++) begin
            c = blank(); c.busy = 1'b1; c.cs_n = 1'b0; c.in_1 = 1'b1; c.pad_oe = 1'b1;
            c.chk_dout = 1'b1; c.dout = wword(w); c.sck = (k >= int'(SCK_DIV));
            c.wr_val = 1'b1; c.wr_data = ~wword(w);
            q.push_back(c);
         end
      end
      if (rn > 0) begin
         for (int k = 0; k < int'(TURN_CYC); k++) begin
            c = blank(); c.busy = 1'b1; c.oe_req = 1'b1;
            if (bogus && k == 0) begin
               c.start = 1'b1; c.wr_num = 8'h03; c.rd_num = 8'hFF;
            end
            q.push_back(c);
         end
         rd_first_idx = q.size();
         for (int r = 0; r < rn; r++) begin
            for (int k = 0; k < int'(2 * SCK_DIV); k++) begin
               c = blank(); c.busy = 1'b1; c.oe_req = 1'b1; c.in_2 = 1'b1;
               c.sck = (k >= int'(SCK_DIV));
               c.pad_din = (k == int'(2 * SCK_DIV) - 1) ? rword(r) : ~rword(r);
               if (r > 0 && k == 0) begin
                  c.rd_val = 1'b1; c.chk_rdata = 1'b1; c.rdata = rword(r - 1);
               end
               q.push_back(c);
            end
         end
      end
      c = blank(); c.busy = 1'b1; c.done = 1'b1;
      if (rn > 0) begin
         c.rd_val = 1'b1; c.chk_rdata = 1'b1; c.rdata = rword(rn - 1);
      end
      q.push_back(c);
      q.push_back(blank());
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0b, required %0b", name, cur, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, required %0h", name, cur, act, exp);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Plays the timeline: drive #1 after the edge, compare at the falling edge.
   task automatic run_q();
      int s;
      cyc_t c;
      s = -1; n_rstlow = 0; n_swhi = 0; first_rdy = -1; done_off = -1; n_rdval = 0;
      rd_gap = -1; last_rdval = -1; n_done = 0; n_oe = 0; n_sck_rise = 0; sck_prev = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         c = q[i];
         @(posedge I_clk);
         #1;
         I_rst = c.rst; I_start = c.start; I_wr_num = c.wr_num; I_rd_num = c.rd_num;
         I_wr_val = c.wr_val; I_wr_data = c.wr_data; I_pad_din = c.pad_din;
         @(negedge I_clk);
         cur = i;
         chk_b("reset_n", O_reset_n, c.reset_n);
         chk_b("sw_clk", O_SW_clk, c.sw_clk);
         chk_b("spi_cs_n", O_spi_cs_n, c.cs_n);
         chk_b("spi_sck", O_spi_sck, c.sck);
         chk_b("oe_req", O_OE_req, c.oe_req);
         chk_b("in_1", O_in_1, c.in_1);
         chk_b("in_2", O_in_2, c.in_2);
         chk_b("pad_oe", O_pad_oe, c.pad_oe);
         chk_b("wr_rdy", O_wr_rdy, c.wr_rdy);
         chk_b("rd_val", O_rd_val, c.rd_val);
         chk_b("busy", O_busy, c.busy);
         chk_b("done", O_done, c.done);
         if (c.chk_dout) chk_w("pad_dout", O_pad_dout, c.dout);
         if (c.chk_rdata) chk_w("rd_data", O_rd_data, c.rdata);
         checks++;
         assert (!(O_pad_oe && O_OE_req)) else begin
            errors++;
            $display("FAIL oe_exclusive @cycle %0d: pad_oe=%0b OE_req=%0b, required not both 1",
                     i, O_pad_oe, O_OE_req);
         end
         if (c.mark) s = i;
         if (s >= 0 && i > s) begin
            if (O_wr_rdy && first_rdy < 0) first_rdy = i - s;
            if (!O_reset_n) n_rstlow++;
            if (O_SW_clk && first_rdy < 0) n_swhi++;
            if (O_done) begin
               n_done++;
               if (done_off < 0) done_off = i - s;
            end
            if (O_rd_val) begin
               n_rdval++;
               if (last_rdval >= 0) rd_gap = i - last_rdval;
               last_rdval = i;
            end
            if (O_pad_oe || O_OE_req) n_oe++;
            if (O_spi_sck && !sck_prev) n_sck_rise++;
         end
         sck_prev = O_spi_sck;
      end
   endtask

   initial begin
      cyc_t c;
      int   k;
      I_rst = 1'b1; I_start = 1'b0; I_wr_val = 1'b0; I_wr_num = '0; I_rd_num = '0;
      I_wr_data = '0; I_pad_din = '0;
      repeat (3) @(posedge I_clk);

      // Reset values, then wr=2 rd=1 with the host always ready.
      chip_up = 1'b0;
      q.delete();
      c = blank(); c.chk_dout = 1'b1; c.chk_rdata = 1'b1;
      q.push_back(c); q.push_back(c);
      build_seq(2, 1, 0, 1'b0);
      run_q();
      lit("s1_reset_low_cycles", n_rstlow, 16);
      lit("s1_swclk_before_rdy", n_swhi, 16);
      lit("s1_first_wr_rdy_offset", first_rdy, 33);
      lit("s1_sck_pulses", n_sck_rise, 3);
      lit("s1_rd_val_pulses", n_rdval, 1);
      lit("s1_done_offset", done_off, 51);

      // Host stalls 10 cycles on the first word; stray starts while busy.
      q.delete();
      build_seq(1, 0, 10, 1'b1);
      run_q();
      lit("s2_first_wr_rdy_offset", first_rdy, 33);
      lit("s2_done_offset", done_off, 48);
      lit("s2_oe_cycles", n_oe, 4);

      // No writes, three reads; stray starts while busy.
      q.delete();
      build_seq(0, 3, 0, 1'b1);
      run_q();
      lit("s3_no_wr_rdy", first_rdy, -1);
      lit("s3_rd_val_pulses", n_rdval, 3);
      lit("s3_rd_val_spacing", rd_gap, 4);
      lit("s3_done_offset", done_off, 49);

      // Empty sequence: done in cycle 34 counting the start cycle as 1.
      q.delete();
      build_seq(0, 0, 0, 1'b0);
      run_q();
      lit("s4_done_offset", done_off, 33);
      lit("s4_oe_cycles", n_oe, 0);
      lit("s4_done_pulses", n_done, 1);

      // Reset in the first cycle of the second read word.
      q.delete();
      build_seq(1, 2, 0, 1'b0);
      k = rd_first_idx + int'(2 * SCK_DIV);
      while (q.size() > k + 1) void'(q.pop_back());
      c = q[k]; c.rst = 1'b1; q[k] = c;
      chip_up = 1'b0;
      c = blank(); c.chk_dout = 1'b1; c.chk_rdata = 1'b1;
      q.push_back(c);
      for (int i = 0; i < 5; i++) q.push_back(blank());
      run_q();
      lit("s5_done_after_abort", n_done, 0);
      lit("s5_rd_val_before_abort", n_rdval, 1);

      // Full sequence after the abort.
      q.delete();
      build_seq(1, 1, 0, 1'b0);
      run_q();
      lit("s6_reset_low_cycles", n_rstlow, 16);
      lit("s6_done_offset", done_off, 46);
      lit("s6_done_pulses", n_done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
